// File: rtl/pcileech_tlp_mrd_responder_if.sv
// RX TLP tap plus CplD buffer handoff between the MRd responder and the TX mux p-port.
interface pcileech_tlp_mrd_responder_if;
  logic [63:0]   rx_data;
  logic [7:0]    rx_keep;
  logic          rx_last;
  logic          rx_valid;
  logic          rx_ready;
  logic [1187:0] tlp_data;
  logic          tlp_has_data;
  logic          tlp_req_data;
  logic          tlp_valid;

  modport master (
    output rx_data, rx_keep, rx_last, rx_valid, rx_ready, tlp_req_data,
    input  tlp_data, tlp_has_data, tlp_valid
  );

  modport slave (
    input  rx_data, rx_keep, rx_last, rx_valid, rx_ready, tlp_req_data,
    output tlp_data, tlp_has_data, tlp_valid
  );
endinterface

// File: rtl/pcileech_tlp_mrd_responder.sv
// Self-test BAR responder: answers MRd32 requests with a CplD whose payload echoes each
// DWORD's own byte address, built in the 18-slot x 66-bit buffer format for tlp128_sink_mux1.
module pcileech_tlp_mrd_responder #(
  parameter int MAX_LEN_DW = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_en,
  input  logic [15:0]                        i_completer_id,
  pcileech_tlp_mrd_responder_if.slave        io_bus,
  output logic [7:0]                         o_drop_cnt,
  output logic                               o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR2  = 3'd1,
    S_SKIP  = 3'd2,
    S_BUILD = 3'd3,
    S_READY = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_sop;
  logic [9:0]    r_len;
  logic [15:0]   r_req_id;
  logic [7:0]    r_tag;
  logic [31:0]   r_addr;
  logic [4:0]    r_cyc;
  logic [1187:0] r_tlp_data;
  logic          r_has_data;
  logic          r_valid;
  logic [7:0]    r_drop_cnt;
  logic          r_busy;

  logic          w_acc;
  logic [31:0]   w_dw0;
  logic [9:0]    w_len;
  logic          w_qual;
  logic          w_drop_state;
  logic [5:0]    w_total;
  logic [5:0]    w_n;
  logic [5:0]    w_lo_idx;
  logic [5:0]    w_hi_idx;
  logic          w_last_slot;
  logic [65:0]   w_slot;
  logic          w_unused;

  // DWORD idx of the completion; positions past the end of the TLP read as zero.
  function automatic logic [31:0] f_cpl_dword(
    input logic [5:0]  idx,
    input logic [5:0]  total,
    input logic [9:0]  len,
    input logic [15:0] cid,
    input logic [15:0] req_id,
    input logic [7:0]  tag,
    input logic [31:0] addr
  );
    logic [31:0] dw;
    if (idx >= total) begin
      dw = 32'h0;
    end else begin
      case (idx)
        6'd0:    dw = {8'h4A, 14'b0, len};
        6'd1:    dw = {cid, 3'b000, 1'b0, len, 2'b00};
        6'd2:    dw = {req_id, tag, 1'b0, addr[6:2], 2'b00};
        default: dw = {addr[31:2] + 30'(idx - 6'd3), 2'b00};
      endcase
    end
    return dw;
  endfunction

  assign w_acc        = io_bus.rx_valid & io_bus.rx_ready;
  assign w_dw0        = io_bus.rx_data[31:0];
  assign w_len        = w_dw0[9:0];
  assign w_qual       = r_sop && (w_dw0[31:24] == 8'h00) && (w_len != 10'd0) &&
                        (w_len <= 10'(MAX_LEN_DW)) && !io_bus.rx_last;
  assign w_drop_state = (r_state == S_HDR2) || (r_state == S_BUILD) ||
                        (r_state == S_READY) || (r_state == S_SEND);

  assign w_total     = 6'(r_len) + 6'd3;
  assign w_n         = 6'((w_total + 6'd1) >> 1);
  assign w_lo_idx    = {r_cyc, 1'b0};
  assign w_hi_idx    = {r_cyc, 1'b1};
  assign w_last_slot = ({1'b0, r_cyc} == (w_n - 6'd1));

  // Slot flags fall out of the indices: [65] upper DWORD valid, [64] final slot.
  assign w_slot = {(w_hi_idx < w_total), w_last_slot,
                   f_cpl_dword(w_hi_idx, w_total, r_len, i_completer_id, r_req_id, r_tag, r_addr),
                   f_cpl_dword(w_lo_idx, w_total, r_len, i_completer_id, r_req_id, r_tag, r_addr)};

  assign w_unused = ^{io_bus.rx_keep, io_bus.rx_data[39:32], w_dw0[23:10]};

  // Capture FSM, drop counter, SOP tracking and buffer assembly with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sop      <= 1'b1;
      r_len      <= 10'd0;
      r_req_id   <= 16'h0;
      r_tag      <= 8'h0;
      r_addr     <= 32'h0;
      r_cyc      <= 5'd0;
      r_tlp_data <= '0;
      r_has_data <= 1'b0;
      r_valid    <= 1'b0;
      r_drop_cnt <= 8'h0;
      r_busy     <= 1'b0;
    end else begin
      if (w_acc) begin
        r_sop <= io_bus.rx_last;
      end
      if (w_acc && w_qual && w_drop_state && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_acc && r_sop && !io_bus.rx_last) begin
            r_busy <= 1'b1;
            if (w_qual && i_en) begin
              r_len    <= w_len;
              r_req_id <= io_bus.rx_data[63:48];
              r_tag    <= io_bus.rx_data[47:40];
              r_state  <= S_HDR2;
            end else begin
              r_state <= S_SKIP;
            end
          end
        end
        S_HDR2: begin
          if (w_acc) begin
            if (io_bus.rx_last) begin
              r_addr  <= io_bus.rx_data[31:0];
              r_cyc   <= 5'd0;
              r_state <= S_BUILD;
            end else begin
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (w_acc && io_bus.rx_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_BUILD: begin
          r_tlp_data[32'(r_cyc) * 32'd66 +: 66] <= w_slot;
          if (w_last_slot) begin
            r_state    <= S_READY;
            r_has_data <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 5'd1;
          end
        end
        S_READY: begin
          if (io_bus.tlp_req_data) begin
            r_state    <= S_SEND;
            r_has_data <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
        S_SEND: begin
          r_valid    <= 1'b0;
          r_tlp_data <= '0;
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_has_data <= 1'b0;
          r_valid    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.tlp_data     = r_tlp_data;
  assign io_bus.tlp_has_data = r_has_data;
  assign io_bus.tlp_valid    = r_valid;
  assign o_drop_cnt          = r_drop_cnt;
  assign o_busy              = r_busy;

endmodule

// File: tb/tb_pcileech_tlp_mrd_responder.sv
// Directed bench for the MRd32 responder: expected CplD buffers are queued when the request
// is driven and compared when the responder strobes tlp_valid.
module tb_pcileech_tlp_mrd_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [15:0] cid = 16'h0300;
  logic [7:0]  drop_cnt;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic [1187:0] sb_q[$];

  pcileech_tlp_mrd_responder_if bus();

  pcileech_tlp_mrd_responder #(.MAX_LEN_DW(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (en),
    .i_completer_id (cid),
    .io_bus         (bus.slave),
    .o_drop_cnt     (drop_cnt),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1187:0] exp_cpl(input int len, input logic [31:0] dw1,
                                            input logic [31:0] addr, input logic [15:0] c);
    logic [31:0]   dw[0:35];
    logic [1187:0] t;
    int total, n;
    for (int i = 0; i < 36; i++) dw[i] = 32'h0;
    dw[0] = {8'h4A, 14'b0, 10'(len)};
    dw[1] = {c, 3'b000, 1'b0, 12'(4 * len)};
    dw[2] = {dw1[31:16], dw1[15:8], 1'b0, addr[6:2], 2'b00};
    for (int j = 0; j < len; j++) dw[3 + j] = {addr[31:2] + 30'(j), 2'b00};
    total = 3 + len;
    n = (total + 1) / 2;
    t = '0;
    for (int k = 0; k < n; k++) begin
      if (k < n - 1) t[66 * k +: 66] = {2'b10, dw[2 * k + 1], dw[2 * k]};
      else if (total % 2 == 0) t[66 * k +: 66] = {2'b11, dw[2 * k + 1], dw[2 * k]};
      else t[66 * k +: 66] = {2'b01, 32'h0, dw[2 * k]};
    end
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tlp(input string tag, input logic [1187:0] obs, input logic [1187:0] exp);
    int k;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      k = 0;
      for (int s = 17; s >= 0; s--) if (obs[66 * s +: 66] !== exp[66 * s +: 66]) k = s;
      $error("FAIL %s: slot %0d observed %h expected %h", tag, k, obs[66 * k +: 66], exp[66 * k +: 66]);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic ready);
    bus.rx_data  = d;
    bus.rx_last  = last;
    bus.rx_valid = 1'b1;
    bus.rx_ready = ready;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    bus.rx_ready = 1'b1;
  endtask

  task automatic send_mrd(input logic [31:0] dw0, input logic [31:0] dw1,
                          input logic [31:0] addr, input bit expect_resp);
    beat({dw1, dw0}, 1'b0, 1'b1);
    if (expect_resp) sb_q.push_back(exp_cpl(int'(dw0[9:0]), dw1, addr, cid));
    beat({32'h0, addr}, 1'b1, 1'b1);
  endtask

  // lat counts edges from the one that accepted the DW2 beat
  task automatic wait_has(input string tag, output int l);
    l = 1;
    while (bus.tlp_has_data !== 1'b1 && l < 200) begin
      step();
      l++;
    end
    chk({tag, "_has_data"}, 66'(bus.tlp_has_data), 66'd1);
  endtask

  task automatic deliver(input string tag);
    bus.tlp_req_data = 1'b1;
    step();
    bus.tlp_req_data = 1'b0;
    chk({tag, "_valid"}, 66'(bus.tlp_valid), 66'd1);
    chk({tag, "_sb_nonempty"}, 66'(sb_q.size() > 0), 66'd1);
    if (sb_q.size() > 0) chk_tlp({tag, "_data"}, bus.tlp_data, sb_q.pop_front());
    step();
    chk({tag, "_valid_1cyc"}, 66'(bus.tlp_valid), 66'd0);
    chk_tlp({tag, "_cleared"}, bus.tlp_data, '0);
    chk({tag, "_idle"}, 66'(busy), 66'd0);
  endtask

  initial begin
    bus.rx_data      = 64'h0;
    bus.rx_keep      = 8'hFF;
    bus.rx_last      = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_ready     = 1'b1;
    bus.tlp_req_data = 1'b0;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_has_data", 66'(bus.tlp_has_data), 66'd0);
    chk("rst_valid", 66'(bus.tlp_valid), 66'd0);
    chk("rst_drop", 66'(drop_cnt), 66'd0);
    chk("rst_busy", 66'(busy), 66'd0);
    chk_tlp("rst_data", bus.tlp_data, '0);

    // L=1 with hand-derived slot contents
    send_mrd(32'h00000001, 32'h01002A0F, 32'h10000010, 1'b1);
    wait_has("L1", lat);
    chk("L1_latency", 66'(lat), 66'd3);
    chk("L1_slot0", bus.tlp_data[65:0], {2'b10, 32'h03000004, 32'h4A000001});
    chk("L1_slot1", bus.tlp_data[131:66], {2'b11, 32'h10000010, 32'h01002A10});
    chk("L1_slot2", bus.tlp_data[197:132], 66'h0);
    deliver("L1");

    // L=2: odd DWORD total, final slot has only its lower DWORD
    send_mrd(32'h00000002, 32'h01002A0F, 32'h10000010, 1'b1);
    wait_has("L2", lat);
    chk("L2_latency", 66'(lat), 66'd4);
    chk("L2_slot2", bus.tlp_data[197:132], {2'b01, 32'h0, 32'h10000014});
    deliver("L2");

    // Oversize and zero-length requests are not answered
    send_mrd(32'h00000009, 32'h01002A0F, 32'h10000010, 1'b0);
    repeat (5) step();
    chk("L9_no_resp", 66'(bus.tlp_has_data), 66'd0);
    chk("L9_idle", 66'(busy), 66'd0);
    send_mrd(32'h00000000, 32'h01002A0F, 32'h10000010, 1'b0);
    repeat (5) step();
    chk("L0_no_resp", 66'(bus.tlp_has_data), 66'd0);
    chk("L0_idle", 66'(busy), 66'd0);
    chk("L9_L0_drop", 66'(drop_cnt), 66'd0);

    // Busy drop while READY; a not-ready lookalike beat must not count
    send_mrd(32'h00000003, 32'h0200110F, 32'h20000FFC, 1'b1);
    wait_has("busy_first", lat);
    chk("L3_latency", 66'(lat), 66'd4);
    beat({32'h0100550F, 32'h00000001}, 1'b0, 1'b0);
    beat({32'h0, 32'h30000000}, 1'b1, 1'b0);
    chk("notready_drop", 66'(drop_cnt), 66'd0);
    send_mrd(32'h00000001, 32'h0100660F, 32'h30000000, 1'b0);
    chk("busy_drop", 66'(drop_cnt), 66'd1);
    chk("busy_still_ready", 66'(bus.tlp_has_data), 66'd1);
    deliver("busy_first");

    // MWr32 whose data beat resembles an MRd header, straight into a real MRd
    beat({32'h01002B0F, 32'h40000002}, 1'b0, 1'b1);
    beat({32'h01002A0F, 32'h00000001}, 1'b0, 1'b1);
    beat({32'h00000000, 32'h00000004}, 1'b1, 1'b0);
    beat({32'h00000000, 32'h00000004}, 1'b1, 1'b1);
    send_mrd(32'h00000004, 32'h0400770F, 32'h4FFFFFF8, 1'b1);
    wait_has("after_mwr", lat);
    chk("after_mwr_latency", 66'(lat), 66'd5);
    chk("after_mwr_drop", 66'(drop_cnt), 66'd1);
    deliver("after_mwr");

    // Reset while READY abandons the completion
    send_mrd(32'h00000005, 32'h0500880F, 32'h00001000, 1'b1);
    wait_has("pre_rst", lat);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    chk("rst_ready_has", 66'(bus.tlp_has_data), 66'd0);
    chk_tlp("rst_ready_data", bus.tlp_data, '0);
    chk("rst_ready_drop", 66'(drop_cnt), 66'd0);
    chk("rst_ready_busy", 66'(busy), 66'd0);
    send_mrd(32'h00000008, 32'h0600990F, 32'hFFFFFFF0, 1'b1);
    wait_has("post_rst", lat);
    chk("L8_latency", 66'(lat), 66'd7);
    deliver("post_rst");

    // Capture disabled during the header beat
    en = 1'b0;
    send_mrd(32'h00000001, 32'h0700AA0F, 32'h10000010, 1'b0);
    en = 1'b1;
    repeat (6) step();
    chk("en0_no_resp", 66'(bus.tlp_has_data), 66'd0);
    chk("en0_idle", 66'(busy), 66'd0);
    chk("sb_drained", 66'(sb_q.size()), 66'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
